i2c_regbank_arbiter: RTL and testbench

Owns the 256 x 8 register bank that the I2C slave exposes and shares it between two requesters: the I2C slave byte engine and the local host port. The block uses a single-access-per-slot state machine with round-robin fairness. It also supports an I2C-side lock, so that a multi-byte I2C transfer is never interleaved with host accesses. A timeout counter stops a stuck bus from holding the lock forever.

---
 rtl/i2c_regbank_pkg.sv | 23 ++
 rtl/i2c_regbank_arbiter_lock_timer.sv | 57 +++++
 rtl/i2c_regbank_arbiter.sv | 157 +++++++++++++++
 tb/tb_i2c_regbank_arbiter.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_regbank_pkg.sv
// i2c_regbank_pkg
// Shared types and defaults for the I2C register bank arbiter:
//   state_t  - arbiter FSM encoding
//   owner_t  - which requester owns the current access
//   *_DEF    - default widths and lock timeout used by the modules' parameters
package i2c_regbank_pkg;

    localparam int          ADDR_W_DEF   = 8;
    localparam int          DATA_W_DEF   = 8;
    localparam logic [15:0] LOCK_TMO_DEF = 16'd50000;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_t;

    typedef enum logic {
        OWN_HOST = 1'b0,
        OWN_I2C  = 1'b1
    } owner_t;

endpackage

// File: rtl/i2c_regbank_arbiter_lock_timer.sv
// i2c_lock_timer
// Holds the I2C-side lock flag and its watchdog.
// Ports:
//   clk_i, rst_n - clock, async active-low reset
//   lock_req     - I2C transaction in progress (raw request for the lock)
//   acq_ok       - arbiter is at a point where the lock may be taken
//   lock         - lock currently held
//   lock_tmo     - one-cycle pulse when the lock is force-released
module i2c_lock_timer
    import i2c_regbank_pkg::*;
#(
    parameter logic [15:0] LOCK_TMO = LOCK_TMO_DEF
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic lock_req,
    input  logic acq_ok,
    output logic lock,
    output logic lock_tmo
);

    logic [15:0] cnt;
    logic        blocked;   // set by a timeout, cleared once lock_req is seen low

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            lock     <= 1'b0;
            lock_tmo <= 1'b0;
            cnt      <= '0;
            blocked  <= 1'b0;
        end else begin
            lock_tmo <= 1'b0;
            if (!lock_req) begin
                blocked <= 1'b0;
            end
            if (lock) begin
                if (!lock_req) begin
                    lock <= 1'b0;
                    cnt  <= '0;
                end else if (cnt == LOCK_TMO - 16'd1) begin
                    // cnt counts held cycles already elapsed, so this edge
                    // ends the LOCK_TMO-th held cycle
                    lock     <= 1'b0;
                    cnt      <= '0;
                    lock_tmo <= 1'b1;
                    blocked  <= 1'b1;
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end else if (lock_req && acq_ok && !blocked) begin
                lock <= 1'b1;
                cnt  <= '0;
            end
        end
    end

endmodule

// File: rtl/i2c_regbank_arbiter.sv
// i2c_regbank_arbiter
// Owns the register bank exposed over I2C and shares it between the I2C byte
// engine and the local host, one access per three-cycle slot, round-robin on
// ties, with an I2C-side lock that keeps the host out of multi-byte transfers.
// Ports:
//   clk_i, rst_n                     - clock, async active-low reset
//   i2c_req_i/we_i/addr_i/wdata_i    - I2C request (held until i2c_ack_o)
//   i2c_lock_i                       - I2C transaction in progress
//   i2c_ack_o, i2c_rdata_o           - I2C completion pulse and read data
//   host_req_i/we_i/addr_i/wdata_i   - host request (held until host_ack_o)
//   host_ack_o, host_rdata_o         - host completion pulse and read data
//   lock_o, lock_tmo_o               - lock held / forced-release pulse
//   busy_o                           - FSM not idle
//
// state  | meaning
// IDLE   | sample requests, pick a winner, latch its fields
// ACCESS | write the bank or capture read data for the owner
// DONE   | owner's ack pulse is on its output
module i2c_regbank_arbiter
    import i2c_regbank_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int          DATA_W   = DATA_W_DEF,
    parameter logic [15:0] LOCK_TMO = LOCK_TMO_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              i2c_req_i,
    input  logic              i2c_we_i,
    input  logic [ADDR_W-1:0] i2c_addr_i,
    input  logic [DATA_W-1:0] i2c_wdata_i,
    input  logic              i2c_lock_i,
    output logic              i2c_ack_o,
    output logic [DATA_W-1:0] i2c_rdata_o,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_ack_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              lock_o,
    output logic              lock_tmo_o,
    output logic              busy_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] bank [DEPTH];

    state_t            state;
    owner_t            owner;
    owner_t            last_grant;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic   host_elig;
    logic   i2c_elig;
    logic   grant_valid;
    owner_t grant;
    logic   lock_acq_ok;

    always_comb begin
        host_elig   = host_req_i && !lock_o;
        i2c_elig    = i2c_req_i;
        grant_valid = host_elig || i2c_elig;
        grant       = OWN_HOST;
        if (host_elig && i2c_elig) begin
            grant = (last_grant == OWN_HOST) ? OWN_I2C : OWN_HOST;
        end else if (i2c_elig) begin
            grant = OWN_I2C;
        end
    end

    // Lock may only be taken between accesses so a host access in flight
    // always finishes before the I2C side gets exclusive use.
    assign lock_acq_ok = (state == IDLE) || (state == DONE);
    assign busy_o      = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= OWN_HOST;
            last_grant   <= OWN_HOST;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i2c_ack_o    <= 1'b0;
            host_ack_o   <= 1'b0;
            i2c_rdata_o  <= '0;
            host_rdata_o <= '0;
        end else begin
            i2c_ack_o  <= 1'b0;
            host_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner      <= grant;
                        last_grant <= grant;
                        if (grant == OWN_I2C) begin
                            we_q    <= i2c_we_i;
                            addr_q  <= i2c_addr_i;
                            wdata_q <= i2c_wdata_i;
                        end else begin
                            we_q    <= host_we_i;
                            addr_q  <= host_addr_i;
                            wdata_q <= host_wdata_i;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (owner == OWN_I2C) begin
                        i2c_ack_o <= 1'b1;
                        if (!we_q) begin
                            i2c_rdata_o <= bank[addr_q];
                        end
                    end else begin
                        host_ack_o <= 1'b1;
                        if (!we_q) begin
                            host_rdata_o <= bank[addr_q];
                        end
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (state == ACCESS && we_q) begin
            bank[addr_q] <= wdata_q;
        end
    end

    i2c_lock_timer #(
        .LOCK_TMO (LOCK_TMO)
    ) u_lock_timer (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .lock_req (i2c_lock_i),
        .acq_ok   (lock_acq_ok),
        .lock     (lock_o),
        .lock_tmo (lock_tmo_o)
    );

endmodule

// File: tb/tb_i2c_regbank_arbiter.sv
// tb_i2c_regbank_arbiter
// Bench for i2c_regbank_arbiter with LOCK_TMO = 16. Each access is timestamped
// in clock cycles; expected data and ack cycles come from a plain array model
// and the "serve whoever did not go last" rule.
module tb_i2c_regbank_arbiter;

    logic       clk;
    logic       rst_n;
    logic       i2c_req, i2c_we, i2c_lock;
    logic [7:0] i2c_addr, i2c_wdata;
    logic       i2c_ack;
    logic [7:0] i2c_rdata;
    logic       host_req, host_we;
    logic [7:0] host_addr, host_wdata;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic       lock, lock_tmo, busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int   rise_cyc  = -1;
    int   fall_cyc  = -1;
    int   tmo_cyc   = -1;
    int   tmo_cnt   = 0;
    logic prev_lock = 1'b0;

    logic [7:0] model_bank [256];
    int         last_served;   // 0 = host served last, 1 = I2C served last

    i2c_regbank_arbiter #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .LOCK_TMO (16'd16)
    ) dut (
        .clk_i        (clk),
        .rst_n        (rst_n),
        .i2c_req_i    (i2c_req),
        .i2c_we_i     (i2c_we),
        .i2c_addr_i   (i2c_addr),
        .i2c_wdata_i  (i2c_wdata),
        .i2c_lock_i   (i2c_lock),
        .i2c_ack_o    (i2c_ack),
        .i2c_rdata_o  (i2c_rdata),
        .host_req_i   (host_req),
        .host_we_i    (host_we),
        .host_addr_i  (host_addr),
        .host_wdata_i (host_wdata),
        .host_ack_o   (host_ack),
        .host_rdata_o (host_rdata),
        .lock_o       (lock),
        .lock_tmo_o   (lock_tmo),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (lock && !prev_lock) rise_cyc = cyc;
        if (!lock && prev_lock) fall_cyc = cyc;
        if (lock_tmo) begin
            tmo_cyc = cyc;
            tmo_cnt++;
        end
        prev_lock = lock;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        i2c_req   = 1'b0; i2c_we = 1'b0; i2c_addr = '0; i2c_wdata = '0; i2c_lock = 1'b0;
        host_req  = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) model_bank[i] = 8'h00;
        last_served = 0;
    endtask

    task automatic host_xfer(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                             output logic [7:0] rdata, output int ack_cyc);
        int n = 0;
        host_we = we; host_addr = addr; host_wdata = wdata; host_req = 1'b1;
        ack_cyc = -1;
        rdata   = 8'hxx;
        while (ack_cyc < 0 && n < 60) begin
            @(negedge clk);
            n++;
            if (host_ack === 1'b1) begin
                ack_cyc = cyc;
                rdata   = host_rdata;
            end
        end
        if (ack_cyc < 0) begin
            checks++; failures++;
            $display("FAIL host_ack_timeout: no host ack within %0d cycles, addr %02h", n, addr);
        end
        @(posedge clk); #1;
        host_req = 1'b0;
    endtask

    task automatic i2c_xfer(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                            output logic [7:0] rdata, output int ack_cyc);
        int n = 0;
        i2c_we = we; i2c_addr = addr; i2c_wdata = wdata; i2c_req = 1'b1;
        ack_cyc = -1;
        rdata   = 8'hxx;
        while (ack_cyc < 0 && n < 60) begin
            @(negedge clk);
            n++;
            if (i2c_ack === 1'b1) begin
                ack_cyc = cyc;
                rdata   = i2c_rdata;
            end
        end
        if (ack_cyc < 0) begin
            checks++; failures++;
            $display("FAIL i2c_ack_timeout: no i2c ack within %0d cycles, addr %02h", n, addr);
        end
        @(posedge clk); #1;
        i2c_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i2c_req = 1'b0; i2c_lock = 1'b0; host_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({i2c_ack, i2c_rdata, host_ack, host_rdata, lock, lock_tmo, busy} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0",
                     {i2c_ack, i2c_rdata, host_ack, host_rdata, lock, lock_tmo, busy});
        end
        do_reset();
        @(negedge clk);
        checks++;
        if ({busy, lock, host_ack, i2c_ack} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_idle: got %b required 0000", {busy, lock, host_ack, i2c_ack});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [7:0] rd;
        int t, ac;
        t = cyc;
        host_xfer(1'b1, 8'h10, 8'h5A, rd, ac);
        checks++;
        if (ac !== t + 2) begin
            failures++;
            $display("FAIL wr_latency: ack cycle %0d required %0d", ac, t + 2);
        end
        t = cyc;
        i2c_xfer(1'b0, 8'h10, 8'h00, rd, ac);
        checks++;
        if (ac !== t + 2) begin
            failures++;
            $display("FAIL rd_latency: ack cycle %0d required %0d", ac, t + 2);
        end
        checks++;
        if (rd !== 8'h5A) begin
            failures++;
            $display("FAIL rd_data: got %02h required 5a", rd);
        end
        @(negedge clk);
        checks++;
        if (host_rdata !== 8'h00) begin
            failures++;
            $display("FAIL host_rdata_hold: got %02h required 00", host_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_tie();
        logic [7:0] rh, ri;
        int t, hc, ic, hc2, ic2;
        do_reset();
        t = cyc;
        fork
            i2c_xfer(1'b0, 8'h01, 8'h00, ri, ic);
            host_xfer(1'b0, 8'h02, 8'h00, rh, hc);
        join
        checks++;
        if (ic !== t + 2 || hc !== t + 5) begin
            failures++;
            $display("FAIL tie_first: i2c ack %0d host ack %0d required %0d %0d", ic, hc, t + 2, t + 5);
        end
        t = cyc;
        fork
            begin
                i2c_xfer(1'b0, 8'h03, 8'h00, ri, ic);
                i2c_xfer(1'b0, 8'h04, 8'h00, ri, ic2);
            end
            begin
                host_xfer(1'b0, 8'h05, 8'h00, rh, hc);
                host_xfer(1'b0, 8'h06, 8'h00, rh, hc2);
            end
        join
        checks++;
        if (ic !== t + 2 || hc !== t + 5 || ic2 !== t + 8 || hc2 !== t + 11) begin
            failures++;
            $display("FAIL tie_alternate: acks i2c %0d,%0d host %0d,%0d required %0d,%0d host %0d,%0d",
                     ic, ic2, hc, hc2, t + 2, t + 8, t + 5, t + 11);
        end
    endtask

    task automatic test_same_addr();
        logic [7:0] rh, ri;
        int t, hc, ic;
        do_reset();
        t = cyc;
        fork
            i2c_xfer(1'b1, 8'h20, 8'h11, ri, ic);
            host_xfer(1'b1, 8'h20, 8'h22, rh, hc);
        join
        checks++;
        if (ic !== t + 2 || hc !== t + 5) begin
            failures++;
            $display("FAIL same_addr_order: i2c %0d host %0d required %0d %0d", ic, hc, t + 2, t + 5);
        end
        host_xfer(1'b0, 8'h20, 8'h00, rh, hc);
        checks++;
        if (rh !== 8'h22) begin
            failures++;
            $display("FAIL same_addr_data: got %02h required 22", rh);
        end
    endtask

    task automatic test_lock();
        logic [7:0] rh, ri;
        int t, hc, ic;
        fall_cyc = -1;
        i2c_lock = 1'b1;
        @(negedge clk);
        checks++;
        if (lock !== 1'b0) begin
            failures++;
            $display("FAIL lock_early: got %b required 0", lock);
        end
        @(negedge clk);
        checks++;
        if (lock !== 1'b1) begin
            failures++;
            $display("FAIL lock_rise: got %b required 1", lock);
        end
        @(posedge clk); #1;
        t = cyc;
        fork
            host_xfer(1'b1, 8'h40, 8'hC3, rh, hc);
            begin
                for (int i = 0; i < 4; i++) begin
                    i2c_xfer(1'b1, 8'h41 + i[7:0], 8'hA0 + i[7:0], ri, ic);
                    checks++;
                    if (ic !== t + 2 + 3 * i) begin
                        failures++;
                        $display("FAIL lock_i2c_wr%0d: ack %0d required %0d", i, ic, t + 2 + 3 * i);
                    end
                end
                i2c_lock = 1'b0;
            end
        join
        checks++;
        if (fall_cyc !== t + 13) begin
            failures++;
            $display("FAIL lock_release: fell at %0d required %0d", fall_cyc, t + 13);
        end
        checks++;
        if (!(hc > fall_cyc && hc - fall_cyc <= 3)) begin
            failures++;
            $display("FAIL lock_host_wait: host ack %0d lock fell %0d required within 3 after", hc, fall_cyc);
        end
        i2c_xfer(1'b0, 8'h40, 8'h00, ri, ic);
        checks++;
        if (ri !== 8'hC3) begin
            failures++;
            $display("FAIL lock_host_data: got %02h required c3", ri);
        end
        host_xfer(1'b0, 8'h43, 8'h00, rh, hc);
        checks++;
        if (rh !== 8'hA2) begin
            failures++;
            $display("FAIL lock_i2c_data: got %02h required a2", rh);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] rh;
        int t, hc;
        do_reset();
        tmo_cnt  = 0;
        tmo_cyc  = -1;
        rise_cyc = -1;
        fall_cyc = -1;
        t = cyc;
        i2c_lock = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        host_xfer(1'b1, 8'h50, 8'h66, rh, hc);
        checks++;
        if (rise_cyc !== t + 1) begin
            failures++;
            $display("FAIL tmo_rise: rose at %0d required %0d", rise_cyc, t + 1);
        end
        checks++;
        if (tmo_cnt !== 1 || tmo_cyc !== t + 17) begin
            failures++;
            $display("FAIL tmo_pulse: count %0d at %0d required 1 at %0d", tmo_cnt, tmo_cyc, t + 17);
        end
        checks++;
        if (fall_cyc !== t + 17) begin
            failures++;
            $display("FAIL tmo_lock_drop: fell at %0d required %0d", fall_cyc, t + 17);
        end
        checks++;
        if (hc !== t + 19) begin
            failures++;
            $display("FAIL tmo_host_next: host ack %0d required %0d", hc, t + 19);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (lock !== 1'b0 || rise_cyc !== t + 1) begin
            failures++;
            $display("FAIL tmo_no_relock: lock %b last rise %0d required 0 and %0d", lock, rise_cyc, t + 1);
        end
        @(posedge clk); #1;
        i2c_lock = 1'b0;
        @(posedge clk); #1;
        i2c_lock = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (lock !== 1'b1) begin
            failures++;
            $display("FAIL tmo_relock: got %b required 1", lock);
        end
        @(posedge clk); #1;
        i2c_lock = 1'b0;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_reset_midaccess();
        logic [7:0] rh;
        int hc, acks;
        host_xfer(1'b1, 8'h30, 8'h55, rh, hc);
        host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'h99; host_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy: got %b required 1", busy);
        end
        rst_n = 1'b0;
        host_req = 1'b0;
        #1;
        checks++;
        if ({i2c_ack, i2c_rdata, host_ack, host_rdata, lock, lock_tmo, busy} !== 21'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got %h required 0",
                     {i2c_ack, i2c_rdata, host_ack, host_rdata, lock, lock_tmo, busy});
        end
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (host_ack === 1'b1) acks++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (host_ack === 1'b1) acks++;
        end
        checks++;
        if (acks !== 0) begin
            failures++;
            $display("FAIL mid_no_ack: saw %0d acks required 0", acks);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) model_bank[i] = 8'h00;
        last_served = 0;
        host_xfer(1'b0, 8'h30, 8'h00, rh, hc);
        checks++;
        if (rh !== 8'h00) begin
            failures++;
            $display("FAIL mid_bank_clear: got %02h required 00", rh);
        end
    endtask

    task automatic test_random();
        logic [7:0] ha, ia, hd, id, rh, ri, exp_h, exp_i;
        logic       hw, iw;
        int         mode, t, hc, ic, exp_hc, exp_ic;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            mode = $urandom_range(0, 2);
            hw = 1'($urandom_range(0, 1)); iw = 1'($urandom_range(0, 1));
            ha = 8'($urandom_range(0, 7));  ia = 8'($urandom_range(0, 7));
            hd = 8'($urandom);              id = 8'($urandom);
            t = cyc;
            exp_h = 8'hxx; exp_i = 8'hxx; exp_hc = -1; exp_ic = -1;
            if (mode == 0) begin
                exp_h = model_bank[ha];
                if (hw) model_bank[ha] = hd;
                exp_hc = t + 2;
                last_served = 0;
                host_xfer(hw, ha, hd, rh, hc);
            end else if (mode == 1) begin
                exp_i = model_bank[ia];
                if (iw) model_bank[ia] = id;
                exp_ic = t + 2;
                last_served = 1;
                i2c_xfer(iw, ia, id, ri, ic);
            end else begin
                if (last_served == 0) begin
                    exp_i = model_bank[ia];
                    if (iw) model_bank[ia] = id;
                    exp_h = model_bank[ha];
                    if (hw) model_bank[ha] = hd;
                    exp_ic = t + 2; exp_hc = t + 5;
                    last_served = 0;
                end else begin
                    exp_h = model_bank[ha];
                    if (hw) model_bank[ha] = hd;
                    exp_i = model_bank[ia];
                    if (iw) model_bank[ia] = id;
                    exp_hc = t + 2; exp_ic = t + 5;
                    last_served = 1;
                end
                fork
                    host_xfer(hw, ha, hd, rh, hc);
                    i2c_xfer(iw, ia, id, ri, ic);
                join
            end
            if (mode != 1) begin
                checks++;
                if (hc !== exp_hc || (!hw && rh !== exp_h)) begin
                    failures++;
                    $display("FAIL rand%0d_host: ack %0d data %02h required %0d %02h",
                             n, hc, rh, exp_hc, hw ? rh : exp_h);
                end
            end
            if (mode != 0) begin
                checks++;
                if (ic !== exp_ic || (!iw && ri !== exp_i)) begin
                    failures++;
                    $display("FAIL rand%0d_i2c: ack %0d data %02h required %0d %02h",
                             n, ic, ri, exp_ic, iw ? ri : exp_i);
                end
            end
        end
        for (int a = 0; a < 8; a++) begin
            i2c_xfer(1'b0, 8'(a), 8'h00, ri, ic);
            checks++;
            if (ri !== model_bank[a]) begin
                failures++;
                $display("FAIL sweep_%0d: got %02h required %02h", a, ri, model_bank[a]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i2c_req = 1'b0; i2c_we = 1'b0; i2c_addr = '0; i2c_wdata = '0; i2c_lock = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        last_served = 0;
        test_reset();
        test_write_read();
        test_tie();
        test_same_addr();
        test_lock();
        test_timeout();
        test_reset_midaccess();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
